// File: rtl/exidy2_hs_ram_arbiter.sv
// exidy2_hs_ram_arbiter
//   Shares the single-port CPU work RAM between the game CPU and the hiscore
//   save/restore engine. A hiscore intent pauses the CPU, waits for the CPU's
//   in-flight access to finish, then lets a few guard cycles pass before it
//   grants the port to the hiscore engine. The port returns to the CPU once
//   both intents drop.
//
// Ports
//   master_clock, RESET_n         clock, synchronous active-low reset
//   cpu_ce/cs/we/addr/dout        CPU bus into the RAM
//   cpu_din                       registered RAM read data to the CPU
//   cpu_hold                      pause request to the CPU
//   hs_address/data_in/write      hiscore bus into the RAM
//   hs_access_read/write          hiscore intents
//   hs_data_out                   registered RAM read data to the hiscore engine
//   hs_grant                      hiscore owns the RAM port
//   hs_err                        sticky: hs_write seen without grant
//   ram_addr/din/we, ram_dout     work RAM port (read data 1 cycle after address)
module exidy2_hs_ram_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic          master_clock,
  input  logic          RESET_n,
  input  logic          cpu_ce,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_hold,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write,
  input  logic          hs_access_read,
  input  logic          hs_access_write,
  output logic [DW-1:0] hs_data_out,
  output logic          hs_grant,
  output logic          hs_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {
    CPU_OWN,
    HOLD,
    DRAIN,
    HS_OWN,
    RELEASE
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;
  logic       guard;     // forces one CPU access between consecutive grants
  logic       mux_hs_q;  // port owner one cycle ago: who ram_dout belongs to
  logic       req;

  assign req = hs_access_read | hs_access_write;

  // Next state
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      CPU_OWN: if (req && !guard) state_nxt = HOLD;
      HOLD: begin
        if (!req) state_nxt = RELEASE;
        else if (cpu_ce) begin
          // this cpu_ce completes the access the CPU had in flight
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!req)                  state_nxt = RELEASE;
        else if (drain_cnt == 4'd0) state_nxt = HS_OWN;
        else                       drain_cnt_nxt = drain_cnt - 4'd1;
      end
      HS_OWN:  if (!req) state_nxt = RELEASE;
      RELEASE: state_nxt = CPU_OWN;
      default: state_nxt = CPU_OWN;
    endcase
  end

  // RAM port mux; writes only pass in states where the owner may write
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = 1'b0;
    case (state)
      CPU_OWN, HOLD: ram_we = cpu_cs & cpu_we & cpu_ce;
      HS_OWN: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = hs_write;
      end
      default: ram_we = 1'b0;
    endcase
  end

  always_ff @(posedge master_clock) begin
    if (!RESET_n) begin
      state       <= CPU_OWN;
      drain_cnt   <= 4'd0;
      guard       <= 1'b0;
      mux_hs_q    <= 1'b0;
      cpu_hold    <= 1'b0;
      hs_grant    <= 1'b0;
      hs_err      <= 1'b0;
      cpu_din     <= '0;
      hs_data_out <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      // hold covers HOLD..RELEASE and drops on entry to CPU_OWN
      cpu_hold  <= (state_nxt != CPU_OWN);
      hs_grant  <= (state_nxt == HS_OWN);
      hs_err    <= hs_err | (hs_write & ~hs_grant);
      mux_hs_q  <= (state == HS_OWN);

      if (state == RELEASE)                 guard <= 1'b1;
      else if (state == CPU_OWN && cpu_ce)  guard <= 1'b0;

      // ram_dout lags the address by a cycle, so route it by last cycle's
      // owner; the side that does not own it keeps its last value
      if (mux_hs_q) hs_data_out <= ram_dout;
      else          cpu_din     <= ram_dout;
    end
  end

endmodule

// File: tb/tb_exidy2_hs_ram_arbiter.sv
// Directed bench for exidy2_hs_ram_arbiter with a behavioural work RAM.
module tb_exidy2_hs_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_ce, cpu_cs, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout, cpu_din;
  logic          cpu_hold;
  logic [AW-1:0] hs_address;
  logic [DW-1:0] hs_data_in, hs_data_out;
  logic          hs_write, hs_access_read, hs_access_write;
  logic          hs_grant, hs_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_clr;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  always #5 clk = ~clk;

  exidy2_hs_ram_arbiter #(.AW(AW), .DW(DW), .DRAIN_CYCLES(2)) dut (
    .master_clock   (clk),
    .RESET_n        (rst_n),
    .cpu_ce         (cpu_ce),
    .cpu_cs         (cpu_cs),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .cpu_hold       (cpu_hold),
    .hs_address     (hs_address),
    .hs_data_in     (hs_data_in),
    .hs_write       (hs_write),
    .hs_access_read (hs_access_read),
    .hs_access_write(hs_access_write),
    .hs_data_out    (hs_data_out),
    .hs_grant       (hs_grant),
    .hs_err         (hs_err),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .ram_dout       (ram_dout)
  );

  // synchronous single-port RAM, read-before-write
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    cpu_ce = 0; cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_dout = '0;
    hs_address = '0; hs_data_in = '0; hs_write = 0;
    hs_access_read = 0; hs_access_write = 0;
    tick(); tick();
    check("rst_hold",  16'(cpu_hold), 16'h0);
    check("rst_grant", 16'(hs_grant), 16'h0);
    check("rst_err",   16'(hs_err), 16'h0);
    check("rst_cdin",  16'(cpu_din), 16'h0);
    check("rst_hdout", 16'(hs_data_out), 16'h0);
    rst_n = 1'b1; mem_clr = 1'b0;
    tick();

    // CPU-only traffic
    cpu_cs = 1; cpu_we = 1; cpu_addr = 10'h123; cpu_dout = 8'h5A;
    #1 check("cpu_we_noce", 16'(ram_we), 16'h0);
    cpu_ce = 1;
    #1 check("cpu_we_ce", 16'(ram_we), 16'h1);
    tick();
    cpu_ce = 0;
    #1 check("cpu_we_after", 16'(ram_we), 16'h0);
    check("mem_123", 16'(mem[10'h123]), 16'h5A);
    cpu_we = 0; cpu_ce = 1; exp_q.push_back(8'h5A);
    tick();
    cpu_ce = 0;
    tick();
    exp_v = exp_q.pop_front();
    check("cpu_rd_123", 16'(cpu_din), 16'(exp_v));
    check("cpu_only_hold",  16'(cpu_hold), 16'h0);
    check("cpu_only_grant", 16'(hs_grant), 16'h0);

    // hiscore read
    hs_address = 10'h123; hs_access_read = 1;
    tick();
    check("hold_rise",  16'(cpu_hold), 16'h1);
    check("hold_grant", 16'(hs_grant), 16'h0);
    tick(); tick();
    check("hold_wait", 16'(hs_grant), 16'h0);
    cpu_ce = 1;
    tick();
    cpu_ce = 0;
    check("drain0", 16'(hs_grant), 16'h0);
    tick();
    check("drain1", 16'(hs_grant), 16'h0);
    tick();
    check("grant_rise", 16'(hs_grant), 16'h1);
    check("grant_addr", 16'(ram_addr), 16'h123);
    exp_q.push_back(8'h5A);
    tick(); tick();
    exp_v = exp_q.pop_front();
    check("hs_rd_123", 16'(hs_data_out), 16'(exp_v));
    check("cpu_din_held", 16'(cpu_din), 16'h5A);

    // hiscore back-to-back writes, then release
    hs_address = 10'h010; hs_data_in = 8'hA5; hs_write = 1;
    #1 check("hs_we", 16'(ram_we), 16'h1);
    check("hs_wdata", 16'(ram_din), 16'hA5);
    tick();
    hs_address = 10'h011; hs_data_in = 8'h3C;
    tick();
    hs_write = 0; hs_access_read = 0;
    check("mem_010", 16'(mem[10'h010]), 16'hA5);
    check("mem_011", 16'(mem[10'h011]), 16'h3C);
    tick();
    // RELEASE: a CPU write attempt must not reach the RAM
    cpu_cs = 1; cpu_we = 1; cpu_ce = 1; cpu_addr = 10'h040; cpu_dout = 8'hEE;
    #1 check("rel_we", 16'(ram_we), 16'h0);
    check("rel_grant", 16'(hs_grant), 16'h0);
    check("rel_hold",  16'(cpu_hold), 16'h1);
    check("rel_addr",  16'(ram_addr), 16'h040);
    tick();
    cpu_ce = 0; cpu_we = 0;
    check("post_rel_hold", 16'(cpu_hold), 16'h0);
    check("mem_040", 16'(mem[10'h040]), 16'h0);
    cpu_addr = 10'h010; cpu_ce = 1; exp_q.push_back(8'hA5);
    tick();
    cpu_ce = 0;
    tick();
    exp_v = exp_q.pop_front();
    check("cpu_rd_010", 16'(cpu_din), 16'(exp_v));

    // CPU write in DRAIN and hs_write before grant are both dropped
    hs_access_write = 1;
    tick();
    check("hold2", 16'(cpu_hold), 16'h1);
    cpu_ce = 1;
    tick();
    cpu_cs = 1; cpu_we = 1; cpu_addr = 10'h020; cpu_dout = 8'h77;
    hs_write = 1; hs_address = 10'h030; hs_data_in = 8'h88;
    #1 check("drain_we", 16'(ram_we), 16'h0);
    check("err_before", 16'(hs_err), 16'h0);
    tick();
    cpu_ce = 0; cpu_we = 0; hs_write = 0;
    check("err_set", 16'(hs_err), 16'h1);
    tick();
    check("grant2", 16'(hs_grant), 16'h1);
    check("mem_020", 16'(mem[10'h020]), 16'h0);
    check("mem_030", 16'(mem[10'h030]), 16'h0);

    // re-request straight through RELEASE
    hs_access_write = 0;
    tick();
    hs_access_read = 1;
    check("rel2_grant", 16'(hs_grant), 16'h0);
    tick();
    check("rel2_hold_off", 16'(cpu_hold), 16'h0);
    tick(); tick(); tick();
    check("guard_blocks", 16'(cpu_hold), 16'h0);
    cpu_ce = 1;
    tick();
    cpu_ce = 0;
    check("guard_ce", 16'(cpu_hold), 16'h0);
    tick();
    check("guard_cleared", 16'(cpu_hold), 16'h1);
    check("err_sticky", 16'(hs_err), 16'h1);

    // reset mid-grant
    cpu_ce = 1;
    tick();
    cpu_ce = 0;
    tick(); tick();
    check("grant3", 16'(hs_grant), 16'h1);
    cpu_addr = 10'h155; hs_address = 10'h2AA;
    rst_n = 1'b0;
    tick();
    check("mrst_grant", 16'(hs_grant), 16'h0);
    check("mrst_hold",  16'(cpu_hold), 16'h0);
    check("mrst_err",   16'(hs_err), 16'h0);
    check("mrst_addr",  16'(ram_addr), 16'h155);
    rst_n = 1'b1; hs_access_read = 0;
    tick();
    check("post_rst_hold", 16'(cpu_hold), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exidy2_hs_ram_arbiter.md
Name: exidy2_hs_ram_arbiter

Overview:
- Shares the single-port CPU work RAM between the game CPU and the hiscore save/restore engine.
- When the hiscore engine raises an access intent, the block holds the CPU through the pause path and lets the CPU finish its current access.
- It then grants the RAM port to the hiscore engine, and returns the port to the CPU once both intents drop.
- It sits inside the exidy2 core, between the CPU bus, the hiscore ports and the work RAM instance.

Parameters:
- AW, 10, RAM address width; matches the hiscore address width.
- DW, 8, RAM data width.
- DRAIN_CYCLES, 2, guard cycles between CPU hold taking effect and hiscore grant (1..15).

Ports:
- master_clock  in  1  system clock; all logic on its rising edge.
- RESET_n  in  1  reset, synchronous, active-low.
- cpu_ce  in  1  CPU clock-enable pulse; a CPU access is committed on a cycle where cpu_ce=1.
- cpu_cs  in  1  CPU selects work RAM.
- cpu_we  in  1  CPU write strobe.
- cpu_addr  in  AW  CPU address.
- cpu_dout  in  DW  CPU write data.
- cpu_din  out  DW  RAM read data to CPU, registered.
- cpu_hold  out  1  pause request to the CPU; ORed into the pause block's request.
- hs_address  in  AW  hiscore address.
- hs_data_in  in  DW  hiscore write data.
- hs_write  in  1  hiscore write strobe.
- hs_access_read  in  1  hiscore read intent.
- hs_access_write  in  1  hiscore write intent.
- hs_data_out  out  DW  RAM read data to hiscore, registered.
- hs_grant  out  1  hiscore owns the RAM port.
- hs_err  out  1  sticky flag: hs_write seen without grant.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DW  RAM read data, valid 1 cycle after ram_addr.

Behaviour:
- Reset (RESET_n=0 at the clock edge) forces state CPU_OWN, regardless of current state. All registered outputs (cpu_hold, hs_grant, hs_err, cpu_din, hs_data_out, drain counter) go to 0. The RAM mux selects the CPU.
- Intent: req = hs_access_read | hs_access_write.
- CPU_OWN:
  - ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=cpu_cs&cpu_we&cpu_ce.
  - cpu_din <= ram_dout every cycle.
  - If req=1 and the starvation guard is clear, go to HOLD and set cpu_hold=1 on the next edge.
  - A CPU write in the same cycle that req rises is performed.
- HOLD:
  - Mux still on the CPU; CPU accesses are still served.
  - Wait for the first cpu_ce=1 cycle, which completes the in-flight CPU access. Then go to DRAIN and load the counter with DRAIN_CYCLES-1.
- DRAIN:
  - Mux on the CPU, but ram_we=0; a CPU write attempt is dropped.
  - Decrement the counter each cycle; at 0 go to HS_OWN.
  - If req drops in HOLD or DRAIN, go to RELEASE.
- HS_OWN:
  - hs_grant=1 (registered, asserted on entry).
  - ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write.
  - hs_data_out <= ram_dout every cycle, so read latency from hs_address is 2 cycles.
  - cpu_din holds its last value.
  - When req=0, go to RELEASE.
- RELEASE:
  - One cycle. hs_grant=0, mux back to the CPU, ram_we=0.
  - Next state is CPU_OWN; cpu_hold deasserts on entry to CPU_OWN.
  - The starvation guard is set.
- Starvation guard:
  - Set on leaving RELEASE.
  - Cleared on the first cpu_ce=1 cycle in CPU_OWN.
  - Guarantees at least one CPU access between consecutive hiscore grants.
- hs_write while hs_grant=0 is ignored (no RAM write) and sets hs_err. Only reset clears hs_err.
- cpu_ce stuck low in HOLD: the block waits indefinitely. There is no timeout.
- hs_address changes in HS_OWN are honoured every cycle; back-to-back writes run at full rate.

Test Plan:
- CPU-only traffic, req=0: CPU writes 0x5A to 0x123, then reads 0x123 -> ram_we pulses only on the cpu_ce cycle; cpu_din=0x5A one cycle after the read; cpu_hold and hs_grant stay 0.
- Hiscore read, DRAIN_CYCLES=2: raise hs_access_read, next cpu_ce 3 cycles later -> cpu_hold=1 one cycle after the request; hs_grant=1 exactly 2 cycles after the cpu_ce; reading 0x123 returns hs_data_out=0x5A 2 cycles after the address.
- Hiscore write then release: in HS_OWN write 0xA5 to 0x010, drop intents -> one RELEASE cycle with ram_we=0; cpu_hold=0 the following cycle; CPU read of 0x010 returns 0xA5.
- CPU write during DRAIN and hs_write before grant: CPU write to 0x020 and hs_write to 0x030 -> neither location changes; hs_err=1 and stays set.
- Re-request straight after release: keep req=1 through RELEASE -> no HOLD entry until one cpu_ce occurs in CPU_OWN.
- Reset mid-grant: RESET_n=0 for 1 cycle in HS_OWN -> next edge has hs_grant=0, cpu_hold=0, hs_err=0, mux on the CPU, state CPU_OWN.
